// File: rtl/rr_xbar_router.sv
// Packet crossbar: per-input packet FIFOs, table route decode on destID, per-output round-robin arbiter.
// Latency: 2 cycles minimum from in_put to out_put (FIFO write, then grant into the output register).
// Backpressure: in_free drops when a FIFO is full; out_free low stalls grants; full-puts and unroutable heads are dropped and counted.
//
// Ports:
//   clk, rst_b            clock, asynchronous active-low reset
//   in_pkt/in_put/in_free per-input packet, put strobe, FIFO-not-full
//   out_pkt/out_put       per-output registered packet and one-cycle valid pulse
//   out_free              per-output downstream can accept a packet next cycle
//   drop_cnt              saturating count of dropped packets
module rr_xbar_router #(
  parameter int          NPORTS    = 4,
  parameter int          DEPTH     = 4,
  parameter int          PKT_W     = 32,
  parameter logic [127:0] ROUTE_MAP = 128'h01010101_01010101_01010101_01030200
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic [NPORTS-1:0][PKT_W-1:0]   in_pkt,
  input  logic [NPORTS-1:0]              in_put,
  output logic [NPORTS-1:0]              in_free,
  output logic [NPORTS-1:0][PKT_W-1:0]   out_pkt,
  output logic [NPORTS-1:0]              out_put,
  input  logic [NPORTS-1:0]              out_free,
  output logic [7:0]                     drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(NPORTS);

  // FIFO storage and pointers; the extra count bit keeps full and empty distinct.
  logic [PKT_W-1:0]               r_mem  [NPORTS][DEPTH];
  logic [AW-1:0]                  r_wptr [NPORTS];
  logic [AW-1:0]                  r_rptr [NPORTS];
  logic [CW-1:0]                  r_cnt  [NPORTS];
  logic [IW-1:0]                  r_last [NPORTS];
  logic [NPORTS-1:0]              r_out_put;
  logic [NPORTS-1:0][PKT_W-1:0]   r_out_pkt;
  logic [7:0]                     r_drop_cnt;

  logic [NPORTS-1:0]              w_free;
  logic [NPORTS-1:0]              w_push;
  logic [NPORTS-1:0]              w_full_drop;
  logic [NPORTS-1:0]              w_vld;
  logic [NPORTS-1:0]              w_unrt;
  logic [NPORTS-1:0]              w_pop;
  logic [NPORTS-1:0]              w_gnt_vld;
  logic [IW-1:0]                  w_gnt_idx [NPORTS];
  logic [PKT_W-1:0]               w_head    [NPORTS];
  logic [7:0]                     w_dest    [NPORTS];
  logic [7:0]                     w_drop_nxt;

  // in_free depends only on registered occupancy, so a same-cycle pop never rescues a push to a full FIFO.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      w_free[i] = (r_cnt[i] != CW'(DEPTH));
      w_vld[i]  = (r_cnt[i] != '0);
      w_head[i] = r_mem[i][r_rptr[i]];
      w_dest[i] = ROUTE_MAP[{w_head[i][27:24], 3'b000} +: 8];
      w_unrt[i] = w_vld[i] && (w_dest[i] >= 8'(NPORTS));
    end
  end

  assign w_push      = in_put & w_free;
  assign w_full_drop = in_put & ~w_free;

  // Round-robin per output: scan from the input after the last winner, first requester wins.
  always_comb begin : p_arb
    logic          found;
    logic [IW-1:0] idx;
    for (int o = 0; o < NPORTS; o++) begin
      found        = 1'b0;
      w_gnt_idx[o] = '0;
      for (int k = 1; k <= NPORTS; k++) begin
        idx = IW'((int'(r_last[o]) + k) % NPORTS);
        if (!found && out_free[o] && w_vld[idx] && (w_dest[idx] == 8'(o))) begin
          found        = 1'b1;
          w_gnt_idx[o] = idx;
        end
      end
      w_gnt_vld[o] = found;
    end
  end

  // Each head targets one output, so grants never collide on an input.
  always_comb begin
    w_pop = w_unrt;
    for (int o = 0; o < NPORTS; o++) begin
      if (w_gnt_vld[o]) w_pop[w_gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin : p_drop
    logic [8:0] sum;
    sum = {1'b0, r_drop_cnt};
    for (int i = 0; i < NPORTS; i++) begin
      sum = sum + 9'(w_full_drop[i]) + 9'(w_unrt[i]);
    end
    w_drop_nxt = (sum > 9'd255) ? 8'hFF : sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NPORTS; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
        r_last[i] <= IW'(NPORTS - 1);
      end
      r_out_put  <= '0;
      r_out_pkt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
      for (int o = 0; o < NPORTS; o++) begin
        if (w_gnt_vld[o]) begin
          r_out_pkt[o] <= w_head[w_gnt_idx[o]];
          r_last[o]    <= w_gnt_idx[o];
        end
      end
      r_out_put  <= w_gnt_vld;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // Storage needs no reset: occupancy governs what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= in_pkt[i];
    end
  end

  assign in_free  = w_free;
  assign out_put  = r_out_put;
  assign out_pkt  = r_out_pkt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_rr_xbar_router.sv
// Bench for rr_xbar_router: directed scenarios plus randomized traffic against a queue-based model.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: exercised through out_free and full-FIFO drops.
module tb_rr_xbar_router;

  localparam int NP = 4;
  localparam int DP = 4;
  // Default map with destID 9 pointed at a nonexistent port.
  localparam logic [127:0] MAP = 128'h01010101_01010701_01010101_01030200;

  logic                  clk;
  logic                  rst_b;
  logic [NP-1:0][31:0]   in_pkt;
  logic [NP-1:0]         in_put;
  logic [NP-1:0]         in_free;
  logic [NP-1:0][31:0]   out_pkt;
  logic [NP-1:0]         out_put;
  logic [NP-1:0]         out_free;
  logic [7:0]            drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rr_xbar_router #(.NPORTS(NP), .DEPTH(DP), .PKT_W(32), .ROUTE_MAP(MAP)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_pkt(in_pkt), .in_put(in_put), .in_free(in_free),
    .out_pkt(out_pkt), .out_put(out_put), .out_free(out_free),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef logic [31:0] pkt_q_t[$];
  pkt_q_t      mq [NP];
  int          m_last [NP];
  logic [NP-1:0] m_put;
  logic [31:0] m_pkt [NP];
  int          m_drop;

  function automatic int route(logic [31:0] p);
    logic [127:0] sh;
    sh = MAP >> (32'(p[27:24]) * 8);
    return int'(sh[7:0]);
  endfunction

  function automatic logic [31:0] mkpkt(int dest, int src, int seq);
    return {4'h0, dest[3:0], src[7:0], seq[15:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      m_last[i] = NP - 1;
      m_pkt[i]  = '0;
    end
    m_put  = '0;
    m_drop = 0;
  endtask

  // Advances the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [NP-1:0] free;
    logic [NP-1:0] pop;
    int drops;
    int s;
    drops = 0;
    pop   = '0;
    for (int i = 0; i < NP; i++) free[i] = (mq[i].size() < DP);
    for (int i = 0; i < NP; i++)
      if (mq[i].size() > 0 && route(mq[i][0]) >= NP) begin
        pop[i] = 1'b1;
        drops++;
      end
    for (int o = 0; o < NP; o++) begin
      m_put[o] = 1'b0;
      if (out_free[o]) begin
        for (int k = 1; k <= NP; k++) begin
          s = (m_last[o] + k) % NP;
          if (!m_put[o] && mq[s].size() > 0 && route(mq[s][0]) == o) begin
            m_put[o]  = 1'b1;
            m_pkt[o]  = mq[s][0];
            m_last[o] = s;
            pop[s]    = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NP; i++) if (pop[i]) void'(mq[i].pop_front());
    for (int i = 0; i < NP; i++)
      if (in_put[i]) begin
        if (free[i]) mq[i].push_back(in_pkt[i]);
        else drops++;
      end
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_put   = '0;
    in_pkt   = '0;
    out_free = '0;
    rst_b    = 1'b0;
    tick();
    rst_b = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_b = 1'b1; in_put = '0; in_pkt = '0; out_free = '0;
    #1 rst_b = 1'b0;
    #2;
    n_checks++; if (out_put !== 4'h0) begin n_fail++; $display("FAIL reset_out_put: got %h want 0", out_put); end
    n_checks++; if (out_pkt !== '0) begin n_fail++; $display("FAIL reset_out_pkt: got %h want 0", out_pkt); end
    n_checks++; if (in_free !== 4'hF) begin n_fail++; $display("FAIL reset_in_free: got %h want f", in_free); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    tick();
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    logic [31:0] p;
    do_reset();
    out_free = 4'hF;
    p = mkpkt(2, 1, 16'h55);
    in_pkt[1] = p;
    in_put = 4'b0010;
    tick();
    in_put = '0;
    n_checks++; if (out_put !== 4'b0000) begin n_fail++; $display("FAIL single_early: out_put %b want 0000", out_put); end
    tick();
    n_checks++; if (out_put !== 4'b1000) begin n_fail++; $display("FAIL single_put: out_put %b want 1000", out_put); end
    n_checks++; if (out_pkt[3] !== p) begin n_fail++; $display("FAIL single_pkt: got %h want %h", out_pkt[3], p); end
    tick();
    n_checks++; if (out_put !== 4'b0000) begin n_fail++; $display("FAIL single_pulse: out_put %b want 0000", out_put); end
    n_checks++; if (out_pkt[3] !== p) begin n_fail++; $display("FAIL single_hold: got %h want %h", out_pkt[3], p); end
  endtask

  task automatic test_round_robin();
    int srcs[3] = '{0, 1, 3};
    logic [31:0] exp;
    do_reset();
    out_free = '0;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 3; j++) in_pkt[srcs[j]] = mkpkt(0, srcs[j], s);
      in_put = 4'b1011;
      tick();
    end
    in_put   = '0;
    out_free = 4'b0001;
    for (int n = 0; n < 9; n++) begin
      tick();
      exp = mkpkt(0, srcs[n % 3], n / 3);
      n_checks++; if (out_put !== 4'b0001) begin n_fail++; $display("FAIL rr_put[%0d]: out_put %b want 0001", n, out_put); end
      n_checks++; if (out_pkt[0] !== exp) begin n_fail++; $display("FAIL rr_order[%0d]: got %h want %h", n, out_pkt[0], exp); end
    end
    tick();
    n_checks++; if (out_put !== 4'b0000) begin n_fail++; $display("FAIL rr_drained: out_put %b want 0000", out_put); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_free = 4'b1011;
    for (int n = 0; n < 5; n++) begin
      in_pkt[2] = mkpkt(1, 2, n);
      in_put    = 4'b0100;
      tick();
      n_checks++; if (in_free[2] !== (n < 3)) begin n_fail++; $display("FAIL bp_in_free[%0d]: got %b want %b", n, in_free[2], (n < 3)); end
      n_checks++; if (out_put !== 4'b0000) begin n_fail++; $display("FAIL bp_stall[%0d]: out_put %b want 0000", n, out_put); end
    end
    in_put = '0;
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_drop: got %0d want 1", drop_cnt); end
    out_free = 4'hF;
    for (int n = 0; n < 4; n++) begin
      tick();
      n_checks++; if (out_put !== 4'b0100) begin n_fail++; $display("FAIL bp_out[%0d]: out_put %b want 0100", n, out_put); end
      n_checks++; if (out_pkt[2] !== mkpkt(1, 2, n)) begin n_fail++; $display("FAIL bp_pkt[%0d]: got %h want %h", n, out_pkt[2], mkpkt(1, 2, n)); end
    end
    tick();
    n_checks++; if (out_put !== 4'b0000) begin n_fail++; $display("FAIL bp_extra: out_put %b want 0000", out_put); end
    n_checks++; if (in_free[2] !== 1'b1) begin n_fail++; $display("FAIL bp_free_back: got %b want 1", in_free[2]); end
  endtask

  task automatic test_unroutable();
    do_reset();
    out_free  = 4'hF;
    in_pkt[0] = mkpkt(9, 0, 0);
    in_put    = 4'b0001;
    tick();
    in_put = '0;
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL unrt_early: got %0d want 0", drop_cnt); end
    tick();
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL unrt_drop: got %0d want 1", drop_cnt); end
    n_checks++; if (out_put !== 4'b0000) begin n_fail++; $display("FAIL unrt_out1: out_put %b want 0000", out_put); end
    tick();
    n_checks++; if (out_put !== 4'b0000) begin n_fail++; $display("FAIL unrt_out2: out_put %b want 0000", out_put); end
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL unrt_hold: got %0d want 1", drop_cnt); end
    // FIFO 0 must be empty: it should take exactly DEPTH more packets.
    out_free = '0;
    for (int n = 0; n < 4; n++) begin
      in_pkt[0] = mkpkt(0, 0, n);
      in_put    = 4'b0001;
      tick();
      n_checks++; if (in_free[0] !== (n < 3)) begin n_fail++; $display("FAIL unrt_empty[%0d]: in_free %b want %b", n, in_free[0], (n < 3)); end
    end
    in_put = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    out_free = '0;
    for (int i = 0; i < NP; i++) in_pkt[i] = mkpkt(0, i, 0);
    in_put = 4'hF;
    repeat (4) tick();
    n_checks++; if (in_free !== 4'h0) begin n_fail++; $display("FAIL sat_full: in_free %h want 0", in_free); end
    for (int c = 1; c <= 75; c++) begin
      tick();
      if (c == 63) begin
        n_checks++; if (drop_cnt !== 8'd252) begin n_fail++; $display("FAIL sat_252: got %0d want 252", drop_cnt); end
      end
      if (c == 64) begin
        n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_clip: got %0d want 255", drop_cnt); end
      end
    end
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_end: got %0d want 255", drop_cnt); end
    in_put = '0;
    tick();
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_free = 4'hF;
    in_put   = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NP; i++) in_pkt[i] = mkpkt(0, i, c);
      tick();
    end
    in_put = '0;
    n_checks++; if (out_put[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_active: out_put %b want 1 on bit 0", out_put); end
    #2 rst_b = 1'b0;
    #1;
    n_checks++; if (out_put !== 4'h0) begin n_fail++; $display("FAIL rstmid_out_put: got %b want 0000", out_put); end
    n_checks++; if (in_free !== 4'hF) begin n_fail++; $display("FAIL rstmid_in_free: got %h want f", in_free); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_drop: got %0d want 0", drop_cnt); end
    tick();
    rst_b = 1'b1;
    model_reset();
    for (int i = 1; i < NP; i++) in_pkt[i] = mkpkt(0, i, 7);
    in_put = 4'b1110;
    tick();
    in_put = '0;
    tick();
    n_checks++; if (out_put !== 4'b0001) begin n_fail++; $display("FAIL rstmid_grant: out_put %b want 0001", out_put); end
    n_checks++; if (out_pkt[0] !== mkpkt(0, 1, 7)) begin n_fail++; $display("FAIL rstmid_prio: got %h want %h", out_pkt[0], mkpkt(0, 1, 7)); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NP; i++) begin
        in_pkt[i]   = $urandom;
        in_put[i]   = ($urandom_range(0, 99) < 45);
        out_free[i] = ($urandom_range(0, 99) < 65);
      end
      model_step();
      tick();
      n_checks++; if (out_put !== m_put) begin n_fail++; $display("FAIL rand_put[%0d]: got %b want %b", c, out_put, m_put); end
      for (int o = 0; o < NP; o++) begin
        n_checks++; if (out_pkt[o] !== m_pkt[o]) begin n_fail++; $display("FAIL rand_pkt[%0d][%0d]: got %h want %h", c, o, out_pkt[o], m_pkt[o]); end
      end
      for (int i = 0; i < NP; i++) begin
        n_checks++; if (in_free[i] !== (mq[i].size() < DP)) begin n_fail++; $display("FAIL rand_free[%0d][%0d]: got %b want %b", c, i, in_free[i], (mq[i].size() < DP)); end
      end
      n_checks++; if (int'(drop_cnt) !== m_drop) begin n_fail++; $display("FAIL rand_drop[%0d]: got %0d want %0d", c, drop_cnt, m_drop); end
    end
    in_put = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_unroutable();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_xbar_router.md
# rr_xbar_router

Parametrised packet-level crossbar core for the NoC router: NPORTS input ports, each with its own DEPTH-entry packet FIFO, a table-driven route decode on destID, and a per-output round-robin arbiter with registered outputs and a free/put handshake on both sides. It replaces the fixed 4-port, fixed-priority packet path between the serial in/out buffers of a router. Unroutable packets and packets put while the port is full are dropped and counted.

## Interface

Parameters:
- NPORTS, 4: number of ports (2..8).
- DEPTH, 4: entries per input FIFO (power of 2, ≥2).
- PKT_W, 32: packet width. destID occupies bits [27:24].
- ROUTE_MAP, 128'h…: 16 entries × 8 bits, entry k at [8k+7:8k] is the output port for destID k. Default maps destID 0→0, 1→2, 2→3, all others→1.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-low.
- in_pkt  in  NPORTS×PKT_W  packet offered on each input.
- in_put  in  NPORTS  in_pkt[i] valid this cycle.
- in_free  out  NPORTS  input FIFO i not full.
- out_pkt  out  NPORTS×PKT_W  packet on each output, registered.
- out_put  out  NPORTS  out_pkt[o] valid, one-cycle pulse per packet.
- out_free  in  NPORTS  downstream o can accept a packet next cycle.
- drop_cnt  out  8  saturating count of dropped packets.

## Operation

- **Input side:**
  - in_put[i] with in_free[i]=1 writes in_pkt[i] into FIFO i at the clock edge.
  - in_put[i] with in_free[i]=0 discards the packet and increments drop_cnt.
  - in_free is computed from registered occupancy only. A push to a full FIFO is dropped even if a pop happens in the same cycle.
- **Route decode:**
  - Head of a non-empty FIFO i requests output ROUTE_MAP[head.destID].
  - If the entry is ≥ NPORTS, the head is popped in that cycle, no output is loaded, and drop_cnt increments.
- **Arbitration, per output o:**
  - Candidates are the inputs whose head requests o.
  - A grant is issued only when out_free[o]=1 and at least one candidate exists.
  - Round-robin: search starts at last_grant[o]+1 modulo NPORTS. last_grant[o] updates only on a grant.
  - The granted input is popped, and out_pkt[o] loads its head.
- Each input requests one output at a time, so at most one pop per FIFO per cycle.
- **drop_cnt:**
  - Increments by the number of drop events in the cycle (full-drops plus unroutable pops).
  - Saturates at 255.
- **Reset values:**
  - FIFOs empty, in_free all 1.
  - out_put 0, out_pkt 0, drop_cnt 0.
  - last_grant = NPORTS-1, so input 0 has first priority.

## Timing

- Edge t samples in_put=1, in_free=1: packet is in the FIFO at t+1.
- Grant at edge t+1 (if out_free[o] is high in that cycle): out_put[o]=1 during the cycle after t+1.
- Minimum in→out latency is 2 cycles.
- out_put[o] is high for exactly one cycle per packet. out_pkt[o] holds its last value otherwise.
- With out_free[o] held high and candidates present, out_put[o] can be high every cycle (one packet per cycle per output).
- out_free[o]=0 during a cycle means no grant at that edge: heads wait, and FIFOs fill and deassert in_free.
- A FIFO write and read in the same cycle on a non-full FIFO: occupancy unchanged, order preserved.
- Pointer wrap: occupancy uses a log2(DEPTH)+1-bit count, so full and empty are unambiguous.
- Async reset mid-transfer: all state and outputs go to reset values immediately. In-flight packets are lost and not counted.

## Test plan

- **Single packet:** NPORTS=4 default map. Put destID=2 on input 1 at cycle 0, out_free=4'hF. Expect out_put[3]=1 at cycle 2 with matching out_pkt, and nothing on other outputs.
- **Round-robin:** inputs 0, 1, 3 each hold 3 packets to destID 0, out_free[0]=1. Expect out_put[0] on consecutive cycles, sources ordered 0,1,3,0,1,3,0,1,3.
- **Backpressure:** out_free[2]=0, put 5 packets destID=1 on input 2, DEPTH=4. Expect in_free[2]=0 after the 4th; the 5th is dropped (drop_cnt=1). Raise out_free[2]: exactly 4 packets emerge in order.
- **Unroutable:** ROUTE_MAP entry 9 = 8'h07 with NPORTS=4, put destID=9. Expect no out_put, drop_cnt increments by 1, and the FIFO empty next cycle.
- **Saturation:** force 300 full-drops. Expect drop_cnt=255 and holding.
- **Reset mid-stream:** assert rst_b=0 while FIFOs are half full and out_put is active. Expect out_put=0, in_free=4'hF, drop_cnt=0 immediately. After release, the first grant on any output goes to the lowest-index candidate.
